ifm_sram_arbiter: RTL
=====================

Name: ifm_sram_arbiter

Overview:
- Sole owner of the IFM SRAM macro wrapper: 912 words x 9 byte lanes, per-lane active-low write enable, CS, OE.
- Shares the macro between two requesters:
  - a write requester: the DMA/loader that fills input feature maps;
  - a read requester: the systolic-array row feeder, whose data returns through a 2-entry response FIFO with backpressure.
- Generates all SRAM control timing, round-robin arbitration and out-of-range protection.

Parameters:
ADDR_W, 10, SRAM address width
DEPTH, 912, number of valid words; addresses >= DEPTH are out of range
LANES, 9, byte lanes per word (equals SYS_HEIGHT)
BYTE_W, 8, bits per lane

Ports:
CK  in  1  clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  write word address
wr_data  in  LANES*BYTE_W  write data; lane i = bits [i*8+7:i*8]
wr_strb  in  LANES  per-lane write enable, active high
rd_valid  in  1  read request
rd_ready  out  1  read accepted this cycle
rd_addr  in  ADDR_W  read word address
rsp_valid  out  1  response FIFO head valid
rsp_ready  in  1  consumer pops head
rsp_data  out  LANES*BYTE_W  response word
oob_err  out  1  sticky out-of-range flag
err_clr  in  1  clears oob_err
sram_A  out  ADDR_W  macro address
sram_DI  out  LANES*BYTE_W  macro write data
sram_WEB  out  LANES  macro per-lane write enable, active low
sram_CS  out  1  macro chip select
sram_OE  out  1  macro output enable
sram_DO  in  LANES*BYTE_W  macro read data

Behaviour:
- Single clock CK; rst synchronous, active high.
- Reset state:
  - FIFO empty, in-flight flag 0, oob_err 0, last_gnt=READ.
  - Outputs: rsp_valid 0, rsp_data 0.
  - SRAM side: sram_CS 0, sram_OE 0, sram_WEB all 1, sram_A 0, sram_DI 0.
- Reset mid-operation discards the in-flight read and FIFO contents; no response is produced for it.
- Arbitration (combinational, per cycle):
  - Write eligible = wr_valid. Read eligible = rd_valid && credit.
  - Only one eligible: that requester is granted.
  - Both eligible: grant the one not in last_gnt. last_gnt updates on every grant.
  - wr_ready = write granted; rd_ready = read granted.
  - Credit = (fifo_count + inflight - pop) < 2, where pop = rsp_valid && rsp_ready. This is a combinational path rsp_ready -> rd_ready.
- SRAM drive in the grant cycle (combinational from grant):
  - In-range write: CS=1, WEB[i] = ~wr_strb[i], A=wr_addr, DI=wr_data, OE=0.
  - Write with wr_strb all zero, or wr_addr >= DEPTH: handshake completes, CS=0, no SRAM access.
  - In-range read: CS=1, WEB all 1, A=rd_addr.
  - Idle: CS=0, WEB all 1; A and DI hold their last values.
- Read pipeline:
  - Read accepted in cycle N sets inflight for cycle N+1.
  - In N+1: sram_OE=1; sram_DO is pushed into the FIFO at the end of N+1.
  - rsp_valid rises in N+2 at the earliest, so read latency is 2.
  - Sustained throughput is 1 read/cycle while rsp_ready=1.
  - A write granted in N+1 is legal. OE for the previous read stays high; DO is unaffected.
- Out-of-range read (rd_addr >= DEPTH):
  - Accepted normally with CS=0.
  - Consumes the in-flight slot; pushes an all-zero word with the same latency.
- oob_err:
  - Set on any accepted out-of-range read or write.
  - Cleared by err_clr; set wins when both occur in the same cycle.
- FIFO:
  - 2 entries, in-order; rsp_data = head.
  - Simultaneous push and pop is allowed.
  - Overflow cannot occur by credit construction; the bench asserts this.

Optional Feature:
IFM_ARB_PERF_EN:
- Defined: adds outputs wr_stall_cnt[15:0] and rd_stall_cnt[15:0].
  - Each counts cycles with valid && !ready on its requester.
  - Counters saturate at 16'hFFFF and clear on rst.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Write addr 5, data lanes 0..8 = 8'h10..8'h18, strb 9'h1FF; then read addr 5 -> sram_CS=1 with sram_WEB=9'h000 in the write cycle; rsp_data lanes = 8'h10..8'h18, rsp_valid exactly 2 cycles after rd_ready.
- Partial write: addr 5, all lanes 8'hFF, strb 9'h003; read addr 5 -> lanes 0..1 = 8'hFF, lanes 2..8 unchanged (8'h12..8'h18).
- wr_valid and rd_valid held 1 for 6 cycles, rsp_ready=1 -> grants alternate W,R,W,R,W,R, first conflict going to write.
- rsp_ready=0, 4 back-to-back reads -> exactly 2 accepted, rd_ready=0 afterwards, FIFO holds 2 entries; raise rsp_ready -> the remaining 2 reads are accepted and all 4 responses return in order.
- Read addr 912 -> rsp_data = 0, sram_CS stays 0, oob_err=1; err_clr in the same cycle as a new out-of-range write -> oob_err remains 1.
- Assert rst the cycle after a read is accepted -> rsp_valid never rises for that read; all outputs hold their reset values in the next cycle.

Source files
------------

// File: rtl/ifm_sram_arbiter_if.sv
// Requester-side bundle for the IFM SRAM arbiter: loader write port,
// row-feeder read port and the read response stream.
interface ifm_sram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int LANES  = 9,
  parameter int BYTE_W = 8
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LANES*BYTE_W-1:0]   wr_data;
  logic [LANES-1:0]          wr_strb;
  logic                      rd_valid;
  logic                      rd_ready;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [LANES*BYTE_W-1:0]   rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ifm_sram_arbiter.sv
// IFM SRAM arbiter: sole owner of the IFM macro (DEPTH words x LANES bytes).
// Round-robin between the loader (write) and row feeder (read), 2-cycle read
// latency into a 2-entry response FIFO, sticky out-of-range flag.
// Optional: define IFM_ARB_PERF_EN to add saturating stall counters.
module ifm_sram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 912,
  parameter int LANES  = 9,
  parameter int BYTE_W = 8
) (
  input  logic                    CK,
  input  logic                    rst,
  ifm_sram_arbiter_if.slave       bus,
  output logic                    oob_err,
  input  logic                    err_clr,
  output logic [ADDR_W-1:0]       sram_A,
  output logic [LANES*BYTE_W-1:0] sram_DI,
  output logic [LANES-1:0]        sram_WEB,
  output logic                    sram_CS,
  output logic                    sram_OE,
  input  logic [LANES*BYTE_W-1:0] sram_DO
`ifdef IFM_ARB_PERF_EN
  ,
  output logic [15:0]             wr_stall_cnt,
  output logic [15:0]             rd_stall_cnt
`endif
);

  localparam int DW = LANES * BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} gnt_e;

  gnt_e              last_gnt;
  logic              inflight, inflight_oob;
  logic [DW-1:0]     fifo_mem [2];
  logic              fifo_wp, fifo_rp;
  logic [1:0]        fifo_cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DW-1:0]     di_q;

  logic              pop, credit, wr_elig, rd_elig, wr_gnt, rd_gnt;
  logic              wr_oob, rd_oob, wr_acc, rd_acc;
  logic [2:0]        occ;

  // Arbitration: credit counts FIFO entries plus the in-flight read, net of
  // this cycle's pop, so a full FIFO drained this cycle still admits a read.
  always_comb begin
    pop     = (fifo_cnt != 2'd0) && bus.rsp_ready;
    occ     = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    credit  = occ < 3'd2;
    wr_elig = bus.wr_valid && !rst;
    rd_elig = bus.rd_valid && credit && !rst;
    wr_gnt  = wr_elig && (!rd_elig || last_gnt == GNT_RD);
    rd_gnt  = rd_elig && (!wr_elig || last_gnt == GNT_WR);
    wr_oob  = {1'b0, bus.wr_addr} >= DEPTH_L;
    rd_oob  = {1'b0, bus.rd_addr} >= DEPTH_L;
    // Only in-range accesses touch the macro; empty-strobe writes are no-ops.
    wr_acc  = wr_gnt && !wr_oob && (|bus.wr_strb);
    rd_acc  = rd_gnt && !rd_oob;
  end

  assign bus.wr_ready  = wr_gnt;
  assign bus.rd_ready  = rd_gnt;
  assign bus.rsp_valid = fifo_cnt != 2'd0;
  assign bus.rsp_data  = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rp] : '0;

  assign sram_CS  = wr_acc || rd_acc;
  assign sram_WEB = wr_acc ? ~bus.wr_strb : '1;
  assign sram_A   = wr_acc ? bus.wr_addr : (rd_acc ? bus.rd_addr : a_q);
  assign sram_DI  = wr_acc ? bus.wr_data : di_q;
  assign sram_OE  = inflight;

  // Address/data hold registers so idle cycles keep the macro pins quiet.
  always_ff @(posedge CK) begin
    if (rst) begin
      a_q  <= '0;
      di_q <= '0;
    end else begin
      if (wr_acc) begin
        a_q  <= bus.wr_addr;
        di_q <= bus.wr_data;
      end else if (rd_acc) begin
        a_q  <= bus.rd_addr;
      end
    end
  end

  // Grant history, read in-flight tracking and sticky error flag.
  always_ff @(posedge CK) begin
    if (rst) begin
      last_gnt     <= GNT_RD;
      inflight     <= 1'b0;
      inflight_oob <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      if (wr_gnt)      last_gnt <= GNT_WR;
      else if (rd_gnt) last_gnt <= GNT_RD;
      inflight     <= rd_gnt;
      inflight_oob <= rd_gnt && rd_oob;
      if ((wr_gnt && wr_oob) || (rd_gnt && rd_oob)) oob_err <= 1'b1;
      else if (err_clr)                             oob_err <= 1'b0;
    end
  end

  // Response FIFO: the in-flight read lands at the end of its OE cycle;
  // out-of-range reads land as an all-zero word.
  always_ff @(posedge CK) begin
    if (rst) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[fifo_wp] <= inflight_oob ? '0 : sram_DO;
        fifo_wp           <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

`ifdef IFM_ARB_PERF_EN
  // Saturating stall counters: cycles a requester waits with valid high.
  always_ff @(posedge CK) begin
    if (rst) begin
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (bus.wr_valid && !wr_gnt && wr_stall_cnt != 16'hFFFF)
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (bus.rd_valid && !rd_gnt && rd_stall_cnt != 16'hFFFF)
        rd_stall_cnt <= rd_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
